// File: rtl/branch_cmp_unit_if.sv
//------------------------------------------------------------------------------
// Module   : branch_cmp_unit_if
// Brief    : Request/response handshake bundle for branch_cmp_unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface branch_cmp_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       op;
  logic [4:0]       rt;
  logic [WIDTH-1:0] rdata1;
  logic [WIDTH-1:0] rdata2;
  logic             out_valid;
  logic             out_ready;
  logic             cmpout;

  modport master (
    output in_valid, op, rt, rdata1, rdata2, out_ready,
    input  in_ready, out_valid, cmpout
  );

  modport slave (
    input  in_valid, op, rt, rdata1, rdata2, out_ready,
    output in_ready, out_valid, cmpout
  );
endinterface

`default_nettype wire

// File: rtl/branch_cmp_unit.sv
//------------------------------------------------------------------------------
// Module   : branch_cmp_unit
// Brief    : Multi-cycle MIPS branch comparator, CHUNK bits per cycle, with a
//            taken-branch counter. Optional CMP_EARLY_EXIT_EN ends the compare
//            as soon as the outcome is determined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_cmp_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_cmp_unit_if.slave       bus,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       taken_cnt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NCHUNK - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CMP  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [5:0] c_OP_REGIMM = 6'b000001;
  localparam logic [5:0] c_OP_BEQ    = 6'b000100;
  localparam logic [5:0] c_OP_BNE    = 6'b000101;
  localparam logic [5:0] c_OP_BLEZ   = 6'b000110;
  localparam logic [5:0] c_OP_BGTZ   = 6'b000111;
  localparam logic [4:0] c_RT_BLTZ   = 5'b00000;
  localparam logic [4:0] c_RT_BGEZ   = 5'b00001;

  logic [1:0]       r_state;
  logic [5:0]       r_op;
  logic [4:0]       r_rt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_differ;
  logic             r_nonzero;
  logic             r_cmpout;
  logic [CNT_W-1:0] r_cnt;

  logic [CHUNK-1:0] w_slice_a;
  logic [CHUNK-1:0] w_slice_b;
  logic             w_differ;
  logic             w_nonzero;
  logic             w_sign;
  logic             w_is_beq, w_is_bne, w_is_blez, w_is_bgtz, w_is_bltz, w_is_bgez;
  logic             w_result;
  logic             w_finish;
  logic             w_deliver;

  // Flags include the slice being evaluated this cycle, so they are final on the last slice.
  assign w_slice_a = r_a[r_idx*CHUNK +: CHUNK];
  assign w_slice_b = r_b[r_idx*CHUNK +: CHUNK];
  assign w_differ  = r_differ  | (w_slice_a != w_slice_b);
  assign w_nonzero = r_nonzero | (w_slice_a != '0);
  assign w_sign    = r_a[WIDTH-1];

  assign w_is_beq  = (r_op == c_OP_BEQ);
  assign w_is_bne  = (r_op == c_OP_BNE);
  assign w_is_blez = (r_op == c_OP_BLEZ);
  assign w_is_bgtz = (r_op == c_OP_BGTZ);
  assign w_is_bltz = (r_op == c_OP_REGIMM) && (r_rt == c_RT_BLTZ);
  assign w_is_bgez = (r_op == c_OP_REGIMM) && (r_rt == c_RT_BGEZ);

  assign w_result = (w_is_beq  & ~w_differ)
                  | (w_is_bne  &  w_differ)
                  | (w_is_blez & (w_sign | ~w_nonzero))
                  | (w_is_bgtz & (~w_sign & w_nonzero))
                  | (w_is_bltz &  w_sign)
                  | (w_is_bgez & ~w_sign);

`ifdef CMP_EARLY_EXIT_EN
  // Sign-only and undefined ops never need more than the first slice.
  assign w_finish = (r_idx == c_LAST_IDX)
                  | ((w_is_beq | w_is_bne) & w_differ)
                  | ((w_is_blez | w_is_bgtz) & w_nonzero)
                  | ~(w_is_beq | w_is_bne | w_is_blez | w_is_bgtz);
`else
  assign w_finish = (r_idx == c_LAST_IDX);
`endif

  assign w_deliver = (r_state == c_DONE) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_op      <= '0;
      r_rt      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_differ  <= 1'b0;
      r_nonzero <= 1'b0;
      r_cmpout  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.in_valid) begin
            r_op      <= bus.op;
            r_rt      <= bus.rt;
            r_a       <= bus.rdata1;
            r_b       <= bus.rdata2;
            r_idx     <= '0;
            r_differ  <= 1'b0;
            r_nonzero <= 1'b0;
            r_state   <= c_CMP;
          end
        end
        c_CMP: begin
          r_differ  <= w_differ;
          r_nonzero <= w_nonzero;
          if (w_finish) begin
            r_cmpout <= w_result;
            r_state  <= c_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        c_DONE: begin
          if (bus.out_ready) begin
            r_cmpout <= 1'b0;
            r_state  <= c_IDLE;
          end
        end
        default: begin
          r_cmpout <= 1'b0;
          r_state  <= c_IDLE;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_deliver && r_cmpout) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = (r_state == c_IDLE);
  assign bus.out_valid = (r_state == c_DONE);
  assign bus.cmpout    = r_cmpout;
  assign taken_cnt     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_cmp_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_branch_cmp_unit
// Brief    : Directed vector bench for branch_cmp_unit (32-bit operands,
//            8-bit chunks, 8-bit counter so wrap-around is reachable).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_cmp_unit;

  localparam int c_CNT_W  = 8;
  localparam int c_NCHUNK = 4;
  localparam int c_NVEC   = 16;
  localparam int c_TMO    = 40;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cnt_clr;
  logic [c_CNT_W-1:0] taken_cnt;
  logic [c_CNT_W-1:0] tb_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_cmp_unit_if #(.WIDTH(32)) bus ();

  branch_cmp_unit #(
    .WIDTH (32),
    .CHUNK (8),
    .CNT_W (c_CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .cnt_clr   (cnt_clr),
    .taken_cnt (taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
    int          lat_ee;
  } vec_t;

  vec_t vecs [c_NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and return once out_valid is seen (or the bound expires).
  task automatic send(input logic [5:0] op, input logic [4:0] rt,
                      input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.rt       = rt;
    bus.rdata1   = a;
    bus.rdata2   = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < c_TMO) begin
      check("cmpout_without_valid", {31'd0, bus.cmpout}, 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input int lat_ee);
`ifdef CMP_EARLY_EXIT_EN
    return lat_ee;
`else
    return c_NCHUNK + 0 * lat_ee;
`endif
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    //            op         rt        a             b             exp  lat_ee
    vecs[0]  = '{6'b000100, 5'h1F, 32'h12345678, 32'h12345678, 1'b1, 4};
    vecs[1]  = '{6'b000101, 5'h00, 32'h000000FF, 32'h000000FE, 1'b1, 1};
    vecs[2]  = '{6'b000110, 5'h00, 32'h00000000, 32'h00000000, 1'b1, 4};
    vecs[3]  = '{6'b000111, 5'h00, 32'h80000000, 32'h00000000, 1'b0, 4};
    vecs[4]  = '{6'b000001, 5'h00, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1};
    vecs[5]  = '{6'b100011, 5'h00, 32'h00000000, 32'h00000000, 1'b0, 1};
    vecs[6]  = '{6'b000100, 5'h00, 32'h12345678, 32'h12345679, 1'b0, 1};
    vecs[7]  = '{6'b000101, 5'h03, 32'hCAFEBABE, 32'hCAFEBABE, 1'b0, 4};
    vecs[8]  = '{6'b000001, 5'h01, 32'h7FFFFFFF, 32'h00000000, 1'b1, 1};
    vecs[9]  = '{6'b000001, 5'h01, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1};
    vecs[10] = '{6'b000001, 5'h02, 32'h80000000, 32'h00000000, 1'b0, 1};
    vecs[11] = '{6'b000110, 5'h00, 32'h00000001, 32'h00000000, 1'b0, 1};
    vecs[12] = '{6'b000111, 5'h00, 32'h00010000, 32'h00000000, 1'b1, 3};
    vecs[13] = '{6'b000110, 5'h00, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1};
    vecs[14] = '{6'b000100, 5'h00, 32'h01000000, 32'h00000000, 1'b0, 4};
    vecs[15] = '{6'b000001, 5'h00, 32'h7FFFFFFF, 32'h00000000, 1'b0, 1};

    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.rt        = '0;
    bus.rdata1    = '0;
    bus.rdata2    = '0;
    bus.out_ready = 1'b1;
    cnt_clr       = 1'b0;
    rst_n         = 1'b0;
    tb_cnt        = '0;

    // Reset state
    #2;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_cmpout",    {31'd0, bus.cmpout},    32'd0);
    check("rst_taken_cnt", {24'd0, taken_cnt},     32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Directed vector table
    for (int i = 0; i < c_NVEC; i++) begin
      send(vecs[i].op, vecs[i].rt, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), lat, exp_lat(vecs[i].lat_ee));
      check($sformatf("v%0d_cmpout", i), {31'd0, bus.cmpout}, {31'd0, vecs[i].exp});
      check($sformatf("v%0d_in_ready_busy", i), {31'd0, bus.in_ready}, 32'd0);
      handshake();
      if (vecs[i].exp) tb_cnt = tb_cnt + 1'b1;
      check($sformatf("v%0d_taken_cnt", i), {24'd0, taken_cnt}, {24'd0, tb_cnt});
      check($sformatf("v%0d_out_valid_after", i), {31'd0, bus.out_valid}, 32'd0);
      check($sformatf("v%0d_cmpout_after", i), {31'd0, bus.cmpout}, 32'd0);
    end

    // Backpressure with in_valid held high throughout
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = 6'b000100;
    bus.rdata1    = 32'hA5A5A5A5;
    bus.rdata2    = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    lat = 0;
    while (!bus.out_valid && lat < c_TMO) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_latency", lat, c_NCHUNK);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_out_valid", k), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("bp%0d_cmpout", k),    {31'd0, bus.cmpout},    32'd1);
      check($sformatf("bp%0d_in_ready", k),  {31'd0, bus.in_ready},  32'd0);
      check($sformatf("bp%0d_taken_cnt", k), {24'd0, taken_cnt},     {24'd0, tb_cnt});
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    tb_cnt = tb_cnt + 1'b1;
    check("bp_taken_cnt_after", {24'd0, taken_cnt}, {24'd0, tb_cnt});
    check("bp_in_ready_after",  {31'd0, bus.in_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check("bp_no_duplicate", {31'd0, bus.out_valid}, 32'd0);
    end

    // Drive counter up to all-ones, then wrap
    while (tb_cnt != {c_CNT_W{1'b1}}) begin
      send(6'b000100, 5'h00, 32'h0, 32'h0, lat);
      handshake();
      tb_cnt = tb_cnt + 1'b1;
    end
    check("cnt_all_ones", {24'd0, taken_cnt}, 32'h000000FF);
    send(6'b000100, 5'h00, 32'h0, 32'h0, lat);
    handshake();
    tb_cnt = tb_cnt + 1'b1;
    check("cnt_wrap", {24'd0, taken_cnt}, 32'd0);

    // cnt_clr coincident with a taken handshake
    send(6'b000100, 5'h00, 32'h0, 32'h0, lat);
    handshake();
    tb_cnt = tb_cnt + 1'b1;
    check("cnt_before_clr", {24'd0, taken_cnt}, 32'd1);
    send(6'b000100, 5'h00, 32'h0, 32'h0, lat);
    cnt_clr = 1'b1;
    handshake();
    cnt_clr = 1'b0;
    tb_cnt = '0;
    check("cnt_clr_priority", {24'd0, taken_cnt}, 32'd0);

    // Reset during the second CMP cycle discards the request
    send(6'b000001, 5'h01, 32'h0, 32'h0, lat);
    handshake();
    tb_cnt = tb_cnt + 1'b1;
    check("pre_rst_cnt", {24'd0, taken_cnt}, {24'd0, tb_cnt});
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 6'b000100;
    bus.rdata1   = 32'h0;
    bus.rdata2   = 32'h0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("midrst_taken_cnt", {24'd0, taken_cnt},     32'd0);
    tb_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready_release", {31'd0, bus.in_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check("midrst_no_result", {31'd0, bus.out_valid}, 32'd0);
    end

    // Unit still functional after the aborted request
    send(6'b000111, 5'h00, 32'h00000100, 32'h0, lat);
    check("final_latency", lat, exp_lat(2));
    check("final_cmpout", {31'd0, bus.cmpout}, 32'd1);
    handshake();
    tb_cnt = tb_cnt + 1'b1;
    check("final_taken_cnt", {24'd0, taken_cnt}, {24'd0, tb_cnt});

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_cmp_unit.md
BRANCH_CMP_UNIT -- requirements
Module: branch_cmp_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter CHUNK, default 8, bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 Parameter CNT_W, default 16, width of the taken-branch counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  request present on op/rt/rdata1/rdata2.
REQ-007 in_ready  output  1  unit can accept a request.
REQ-008 op  input  6  instruction opcode field.
REQ-009 rt  input  5  rt field, used only when op = REGIMM.
REQ-010 rdata1  input  WIDTH  first operand (rs).
REQ-011 rdata2  input  WIDTH  second operand (rt).
REQ-012 out_valid  output  1  cmpout holds a valid result.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 cmpout  output  1  1 = branch taken.
REQ-015 taken_cnt  output  CNT_W  count of taken results delivered.
REQ-016 cnt_clr  input  1  synchronous clear of taken_cnt.

Function
REQ-017 Decode: beq 000100 (a==b); bne 000101 (a!=b); blez 000110 (a<=0 signed); bgtz 000111 (a>0 signed); REGIMM 000001 with rt 00000 bltz (a<0), rt 00001 bgez (a>=0); any other op/rt SHALL give cmpout 0.
REQ-018 FSM states IDLE, CMP, DONE; in_ready = 1 only in IDLE.
REQ-019 IDLE: on in_valid && in_ready, capture op, rt, rdata1, rdata2, set chunk index 0, go to CMP.
REQ-020 CMP: each cycle evaluate one CHUNK slice, LSB slice first; accumulate a "differ" flag (rdata1 slice != rdata2 slice) and a "nonzero" flag (rdata1 slice != 0).
REQ-021 CMP: after slice NCHUNK-1 is evaluated, register cmpout and go to DONE; out_valid rises exactly NCHUNK cycles after the accepting edge (4 for defaults).
REQ-022 Sign is taken from captured rdata1[WIDTH-1]; blez = sign | !nonzero; bgtz = !sign & nonzero.
REQ-023 DONE: out_valid = 1; cmpout and out_valid held stable until out_ready = 1; on out_valid && out_ready go to IDLE.
REQ-024 in_valid while not in IDLE is ignored; no request is ever lost or duplicated when in_valid is held through backpressure.
REQ-025 taken_cnt increments by 1 on each out_valid && out_ready cycle with cmpout = 1; wraps from all-ones to 0.
REQ-026 cnt_clr = 1 forces taken_cnt to 0 on the next edge and has priority over a simultaneous increment.
REQ-027 cmpout SHALL be 0 whenever out_valid = 0.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, out_valid 0, cmpout 0, taken_cnt 0, chunk index 0, accumulated flags 0.
REQ-029 Reset asserted mid-CMP or in DONE SHALL discard the pending request; no result is delivered afterwards.
REQ-030 in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Configuration
REQ-031 Macro CMP_EARLY_EXIT_EN defined: in CMP, go to DONE on the cycle after the first slice where the result is already determined (differ set for beq/bne; nonzero set for blez/bgtz); bltz, bgez and undefined ops complete after 1 CMP cycle.
REQ-032 Macro CMP_EARLY_EXIT_EN undefined: every request takes exactly NCHUNK CMP cycles regardless of op or data.

Verification
REQ-033 beq, rdata1 = rdata2 = 0x12345678, out_ready = 1 -> out_valid at cycle 4, cmpout 1, taken_cnt 1.
REQ-034 bne, rdata1 = 0x000000FF, rdata2 = 0x000000FE -> cmpout 1; with CMP_EARLY_EXIT_EN result at cycle 1, without at cycle 4.
REQ-035 blez with 0x00000000 -> 1; bgtz with 0x80000000 -> 0; REGIMM rt=00000 with 0xFFFFFFFF -> 1; op 100011 -> 0.
REQ-036 out_ready held 0 for 5 cycles in DONE -> out_valid and cmpout stable, in_ready 0, taken_cnt unchanged until handshake.
REQ-037 rst_n pulled low in the 2nd CMP cycle -> out_valid 0 immediately, in_ready 1 after release, no result emitted.
REQ-038 taken_cnt preloaded to 0xFFFF by taken results, one more taken result -> 0x0000; cnt_clr coincident with a taken handshake -> 0.
